// File: rtl/rv32imf_pkg.sv
// Shared types and constants for the rv32imf fetch front end.
package rv32imf_pkg;

  // Prefetch request FSM: IDLE decides whether to issue, WAIT_GNT holds a request until granted.
  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_GNT = 1'b1
  } prefetch_state_e;

  // Default number of bus requests the prefetcher may have in flight.
  localparam int unsigned PREFETCH_MAX_OUT = 2;

  // Clear the byte offset so every fetch address is word aligned.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/rv32imf_prefetch_ctrl.sv
// Instruction prefetch controller: issues word-aligned fetch requests to the bus,
// tracks in-flight requests and drops responses belonging to pre-branch requests.
module rv32imf_prefetch_ctrl
  import rv32imf_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned MAX_OUT = PREFETCH_MAX_OUT
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     req_i,
  input  logic                     branch_i,
  input  logic [31:0]              branch_addr_i,
  output logic                     trans_valid_o,
  input  logic                     trans_ready_i,
  output logic [31:0]              trans_addr_o,
  input  logic                     resp_valid_i,
  input  logic [$clog2(DEPTH):0]   fifo_cnt_i,
  output logic                     fifo_push_o,
  output logic                     fifo_flush_o,
  output logic                     busy_o
);

  // One spare count of headroom: a branch may issue even when MAX_OUT requests are in flight.
  localparam int unsigned OutW = $clog2(MAX_OUT + 2);

  prefetch_state_e  state_q, state_d;
  logic [OutW-1:0]  out_q, out_d;
  logic [OutW-1:0]  flush_q, flush_d;
  logic [31:0]      addr_q, addr_d;
  logic             rst_dly_q;

  logic             w_valid;
  logic             w_accept;
  logic             w_below_max;
  logic             w_room;
  logic [31:0]      w_fill;
  logic [31:0]      w_branch_addr;

  assign w_branch_addr = align_word(branch_addr_i);
  assign w_fill        = 32'(fifo_cnt_i) + 32'(out_q);
  // Every in-flight response must still fit in the FIFO once it lands.
  assign w_room        = (w_fill < 32'(DEPTH));
  assign w_below_max   = (32'(out_q) < 32'(MAX_OUT));
  assign w_accept      = w_valid & trans_ready_i;

  // Request FSM next state and bus request valid.
  always_comb begin
    state_d = state_q;
    w_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        w_valid = branch_i | (req_i & w_below_max & w_room);
        if (w_valid && !trans_ready_i) begin
          state_d = WAIT_GNT;
        end
      end
      WAIT_GNT: begin
        // A presented request is never withdrawn, even if req_i drops.
        w_valid = 1'b1;
        if (trans_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        w_valid = 1'b0;
      end
    endcase
  end

  // Outstanding count, discard count and fetch address next-state.
  always_comb begin
    out_d = out_q;
    if (w_accept && !resp_valid_i) begin
      out_d = out_q + OutW'(1);
    end else if (!w_accept && resp_valid_i) begin
      out_d = out_q - OutW'(1);
    end

    flush_d = flush_q;
    if (branch_i) begin
      // Responses still due for requests accepted before this cycle are stale.
      flush_d = out_q - OutW'(resp_valid_i);
    end else if (resp_valid_i && (flush_q != '0)) begin
      flush_d = flush_q - OutW'(1);
    end

    addr_d = addr_q;
    if (w_accept) begin
      addr_d = trans_addr_o + 32'd4;
    end else if (branch_i) begin
      addr_d = w_branch_addr;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      out_q   <= '0;
      flush_q <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      flush_q <= flush_d;
      addr_q  <= addr_d;
    end
  end

  // Remembers that the previous edge was a reset edge, to mask pushes for one more cycle.
  always_ff @(posedge clk_i) begin
    rst_dly_q <= ~rst_ni;
  end

  assign trans_valid_o = w_valid;
  assign trans_addr_o  = branch_i ? w_branch_addr : addr_q;
  assign fifo_flush_o  = branch_i;
  assign fifo_push_o   = resp_valid_i & (flush_q == '0) & ~branch_i & rst_ni & ~rst_dly_q;
  assign busy_o        = (out_q != '0) | w_valid;

`ifdef rv32imf_ASSERT_ON
  // A response with nothing in flight means the bus and this block disagree.
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(resp_valid_i && (out_q == '0)))
    else $error("response with no outstanding request");

  assert property (@(posedge clk_i) disable iff (!rst_ni) trans_addr_o[1:0] == 2'b00)
    else $error("unaligned fetch address");

  assert property (@(posedge clk_i) disable iff (!rst_ni)
                   (state_q == WAIT_GNT) |-> trans_valid_o)
    else $error("request dropped while waiting for grant");
`endif

endmodule

// File: doc/rv32imf_prefetch_ctrl.md
RV32IMF_PREFETCH_CTRL -- requirements
Module: rv32imf_prefetch_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4: depth of the instruction FIFO this block fills; legal range 2..16.
REQ-002 SHALL have parameter MAX_OUT, default 2: maximum outstanding bus requests; legal range 1..3.
REQ-003 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_ni  in  1  reset, synchronous and active-low.
REQ-005 req_i  in  1  fetch enable from the core.
REQ-006 branch_i  in  1  redirect fetch, single-cycle pulse.
REQ-007 branch_addr_i  in  32  redirect target.
REQ-008 trans_valid_o  out  1  bus request valid.
REQ-009 trans_ready_i  in  1  bus request grant.
REQ-010 trans_addr_o  out  32  bus request address, always word aligned.
REQ-011 resp_valid_i  in  1  one in-order response per granted request.
REQ-012 fifo_cnt_i  in  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-013 fifo_push_o  out  1  push the current response data into the FIFO.
REQ-014 fifo_flush_o  out  1  flush the FIFO.
REQ-015 busy_o  out  1  requests are outstanding or pending.

Function
REQ-016 SHALL implement FSM states IDLE and WAIT_GNT.
- IDLE -> WAIT_GNT when trans_valid_o=1 and trans_ready_i=0.
- WAIT_GNT -> IDLE on trans_ready_i=1.
REQ-017 SHALL hold outstanding counter out_q (0..MAX_OUT).
- out_n = out_q + accept - resp_valid_i, where accept = trans_valid_o & trans_ready_i.
- Simultaneous accept and response leaves out_q unchanged.
REQ-018 In IDLE, trans_valid_o SHALL be 1 iff branch_i=1, or all of the following hold: req_i=1, out_q<MAX_OUT, and fifo_cnt_i+out_q<DEPTH (no FIFO overflow possible).
REQ-019 In WAIT_GNT, trans_valid_o SHALL be 1 regardless of req_i and FIFO occupancy.
REQ-020 trans_addr_o SHALL equal {branch_addr_i[31:2],2'b00} when branch_i=1, else addr_q.
REQ-021 addr_q update rules:
- On accept, addr_q <= trans_addr_o+4 (32-bit wrap, 0xFFFFFFFC -> 0x0).
- On branch_i without accept, addr_q <= aligned branch_addr_i; in WAIT_GNT this retargets the pending request.
- Otherwise addr_q is held.
REQ-022 fifo_flush_o SHALL equal branch_i, combinationally.
REQ-023 On branch_i, discard counter flush_q SHALL load out_q-resp_valid_i.
- This counts responses still due for pre-branch requests.
- A request accepted in the branch cycle is post-branch and is not discarded.
REQ-024 Otherwise flush_q SHALL decrement on each resp_valid_i while flush_q>0.
REQ-025 fifo_push_o SHALL be resp_valid_i & (flush_q==0) & ~branch_i.
REQ-026 busy_o SHALL be (out_q!=0) | trans_valid_o.
REQ-027 resp_valid_i with out_q==0 is illegal: an assertion SHALL fire; RTL behaviour is undefined.
REQ-028 Deasserting req_i SHALL NOT cancel a WAIT_GNT request or drop outstanding responses.

Reset
REQ-029 While rst_ni=0 at a clock edge, SHALL set state=IDLE, out_q=0, flush_q=0, addr_q=0.
REQ-030 During reset and one cycle after, fifo_push_o=0 and fifo_flush_o=0 unless branch_i=1.
REQ-031 Responses to requests issued before a mid-operation reset are the system's responsibility; the block SHALL NOT track them.

Structure
REQ-032 SHALL declare enum prefetch_state_e {IDLE, WAIT_GNT} and constant PREFETCH_MAX_OUT=2 in rv32imf_pkg.
REQ-033 SHALL contain no sub-module.
- The parent instantiates it beside rv32imf_fifo.
- fifo_push_o drives push_i, fifo_flush_o drives flush_i, cnt_o drives fifo_cnt_i.
REQ-034 Target size is 120-250 RTL lines, plus assertions under rv32imf_ASSERT_ON.

Verification
REQ-035 Branch then stream:
- Stimulus: reset, branch_i with addr 0x103, req_i=1, ready=1, 1-cycle responses.
- Response: addresses 0x100, 0x104, 0x108...; out_q never exceeds 2.
REQ-036 Grant stall with retarget:
- Stimulus: ready=0 for 3 cycles; branch to 0x200 in cycle 2.
- Response: valid held high; addr 0x100 until the branch, then 0x200; grant yields next addr 0x204.
REQ-037 Discard after branch:
- Stimulus: 2 outstanding, branch with no response that cycle, then 2 responses.
- Response: fifo_flush_o pulses; both responses are dropped; the third response is pushed.
REQ-038 FIFO backpressure:
- Stimulus: DEPTH=4, fifo_cnt_i=3, out_q=1.
- Response: trans_valid_o=0; after fifo_cnt_i drops to 2, issue resumes.
REQ-039 Address wrap:
- Stimulus: branch to 0xFFFFFFFC, grant.
- Response: next trans_addr_o=0x00000000.
REQ-040 Mid-operation reset:
- Stimulus: rst_ni=0 for 1 cycle while in WAIT_GNT with out_q=2.
- Response: trans_valid_o=0, busy_o=0, and addr_q=0 after the edge.
